// File: rtl/stage_timer_if.sv
// stage_timer_if: control, countdown limit, stage-record and display signals
// exchanged between a stage_timer (slave) and its host (master).
interface stage_timer_if;
  logic        run;
  logic        clear;
  logic        mode;
  logic [6:0]  limit_min;
  logic [5:0]  limit_sec;
  logic        blank;
  logic        record;
  logic [2:0]  stage_id;
  logic [15:0] nums;
  logic [15:0] best_nums;
  logic        running;
  logic        done;
  logic        expired;

  modport master (
    output run, clear, mode, limit_min, limit_sec, blank, record, stage_id,
    input  nums, best_nums, running, done, expired
  );

  modport slave (
    input  run, clear, mode, limit_min, limit_sec, blank, record, stage_id,
    output nums, best_nums, running, done, expired
  );
endinterface

// File: rtl/stage_timer.sv
// stage_timer: mm:ss up/down stage timer with saturation, BCD display and
// optional per-stage best-time records compiled in by STAGE_TIMER_BEST_EN.
module stage_timer #(
  parameter int unsigned TICK_DIV   = 100000000,
  parameter int unsigned MAX_MIN    = 99,
  parameter int unsigned NUM_STAGES = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  stage_timer_if.slave bus
);

  localparam int unsigned   PW      = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_TOP = PW'(TICK_DIV - 1);
  localparam logic [6:0]    MAXM    = 7'(MAX_MIN);
  localparam logic [5:0]    SEC_TOP = 6'd59;
  localparam logic [15:0]   BLANK   = 16'hAAAA;

  // IDLE holds the time after reset until the first clear; ARM is the one
  // cycle between a countdown load of 00:00 and done.
  typedef enum logic [1:0] {ST_IDLE, ST_COUNT, ST_ARM, ST_DONE} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [6:0]    min_q, min_d;
  logic [5:0]    sec_q, sec_d;
  logic [15:0]   nums_q, nums_d;
  logic [15:0]   best_nums_q;
  logic          done_q, done_d;
  logic          expired_q, expired_d;
  logic          running_q, running_d;
  logic          cnt_en, tick, terminal, time_zero;
  logic [6:0]    lim_min;
  logic [5:0]    lim_sec;

  function automatic logic [7:0] bcd8(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

  // Prescaler, time update, done tracking and display next-state
  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    min_d     = min_q;
    sec_d     = sec_q;
    terminal  = 1'b0;
    lim_min   = (bus.limit_min > MAXM) ? MAXM : bus.limit_min;
    lim_sec   = (bus.limit_sec > SEC_TOP) ? SEC_TOP : bus.limit_sec;
    time_zero = (min_q == 7'd0) && (sec_q == 6'd0);
    cnt_en    = bus.run && ((state_q == ST_COUNT) || (state_q == ST_ARM));
    tick      = cnt_en && (pre_q == PRE_TOP) && !(bus.mode && time_zero);

    if (cnt_en) begin
      pre_d = (pre_q == PRE_TOP) ? '0 : pre_q + PW'(1);
    end

    if (tick) begin
      if (!bus.mode) begin
        if ((min_q == MAXM) && (sec_q >= 6'd58)) begin
          min_d    = MAXM;
          sec_d    = SEC_TOP;
          terminal = 1'b1;
        end else if (sec_q == SEC_TOP) begin
          min_d = min_q + 7'd1;
          sec_d = '0;
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end else begin
        if (sec_q == 6'd0) begin
          min_d = min_q - 7'd1;
          sec_d = SEC_TOP;
        end else begin
          sec_d = sec_q - 6'd1;
        end
        terminal = (min_q == 7'd0) && (sec_q == 6'd1);
      end
    end

    case (state_q)
      ST_COUNT: if (terminal) state_d = ST_DONE;
      ST_ARM:   state_d = ST_DONE;
      default:  state_d = state_q;
    endcase

    // Reload wins over any tick in the same cycle
    if (bus.clear) begin
      pre_d = '0;
      if (bus.mode) begin
        min_d   = lim_min;
        sec_d   = lim_sec;
        state_d = ((lim_min == 7'd0) && (lim_sec == 6'd0)) ? ST_ARM : ST_COUNT;
      end else begin
        min_d   = '0;
        sec_d   = '0;
        state_d = ST_COUNT;
      end
    end

    done_d    = (state_d == ST_DONE);
    expired_d = done_d && (state_q != ST_DONE);
    running_d = bus.run && ((state_d == ST_COUNT) || (state_d == ST_ARM));
    nums_d    = bus.blank ? BLANK : {bcd8(min_q), bcd8({1'b0, sec_q})};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pre_q     <= '0;
      min_q     <= '0;
      sec_q     <= '0;
      nums_q    <= BLANK;
      done_q    <= 1'b0;
      expired_q <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      nums_q    <= nums_d;
      done_q    <= done_d;
      expired_q <= expired_d;
      running_q <= running_d;
    end
  end

`ifdef STAGE_TIMER_BEST_EN
  logic [12:0]           best_q [NUM_STAGES];
  logic [12:0]           best_d [NUM_STAGES];
  logic [NUM_STAGES-1:0] valid_q, valid_d;
  logic [15:0]           best_nums_d;
  logic [12:0]           cur_time;

  // {min,sec} orders like total seconds because sec never exceeds 59
  assign cur_time = {min_q, sec_q};

  always_comb begin
    best_d      = best_q;
    valid_d     = valid_q;
    best_nums_d = BLANK;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      if (bus.stage_id == 3'(i)) begin
        if (valid_q[i]) begin
          best_nums_d = {bcd8(best_q[i][12:6]), bcd8({1'b0, best_q[i][5:0]})};
        end
        if (bus.record && (!valid_q[i] ||
            (bus.mode ? (cur_time > best_q[i]) : (cur_time < best_q[i])))) begin
          best_d[i]  = cur_time;
          valid_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q     <= '0;
      best_nums_q <= BLANK;
      for (int unsigned i = 0; i < NUM_STAGES; i++) begin
        best_q[i] <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      best_nums_q <= best_nums_d;
      best_q      <= best_d;
    end
  end
`else
  logic unused_best;
  assign unused_best = ^{bus.record, bus.stage_id, 3'(NUM_STAGES)};

  always_ff @(posedge clk) begin
    best_nums_q <= BLANK;
  end
`endif

  assign bus.nums      = nums_q;
  assign bus.best_nums = best_nums_q;
  assign bus.done      = done_q;
  assign bus.expired   = expired_q;
  assign bus.running   = running_q;

endmodule
